// File: rtl/ysyx_040750_dmem_responder.sv
// ---------------------------------------------------------------------------
// ysyx_040750_dmem_responder
// Memory-side responder for the MEM-stage load/store handshake. One request
// is taken per handshake and serviced from a 64-bit word SRAM model. After
// LATENCY cycles the responder gives a one-cycle rvalid pulse (load) or a
// one-cycle bvalid pulse (store). Only one request is outstanding at a time.
//
// Ports
//   I_sys_clk          clock; all state changes on the rising edge
//   I_rst              synchronous active-high reset
//   I_mem_rd_en        read request, held by the requester until accepted
//   I_mem_wr_en        write request, held by the requester until accepted
//   I_addr             byte address
//   I_wdata/I_wstrb    lane-aligned store data and byte enables
//   I_rstrb            [7:0] unshifted size mask, [8] sign-extend select
//   O_mem_ready        request can be accepted this cycle (IDLE)
//   O_mem_data_rvalid  load response pulse
//   O_mem_data_bvalid  store response pulse
//   O_rdata            extended load data, held until the next load response
//   O_resp_err         out-of-range flag, valid with the response pulse
// ---------------------------------------------------------------------------
module ysyx_040750_dmem_responder #(
    parameter int          MEM_WORDS = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic        I_sys_clk,
    input  logic        I_rst,
    input  logic        I_mem_rd_en,
    input  logic        I_mem_wr_en,
    input  logic [63:0] I_addr,
    input  logic [63:0] I_wdata,
    input  logic [7:0]  I_wstrb,
    input  logic [8:0]  I_rstrb,
    output logic        O_mem_ready,
    output logic        O_mem_data_rvalid,
    output logic        O_mem_data_bvalid,
    output logic [63:0] O_rdata,
    output logic        O_resp_err
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        is_rd_q;     // latched request type
    logic        err_q;       // latched range-check result
    logic [63:0] ldata_q;     // load result captured at accept
    logic        rvalid_q, bvalid_q, resp_err_q;
    logic [63:0] rdata_q;

    logic [63:0] mem [MEM_WORDS];

    logic          accept;
    logic          acc_wr;
    logic [63:0]   off;
    logic          in_range;
    logic [AW-1:0] idx;
    logic [63:0]   word;
    logic [63:0]   shifted;
    logic [63:0]   lane_mask;
    logic          sbit;
    logic [63:0]   load_val;

    assign O_mem_ready       = (state_q == S_IDLE);
    assign O_mem_data_rvalid = rvalid_q;
    assign O_mem_data_bvalid = bvalid_q;
    assign O_rdata           = rdata_q;
    assign O_resp_err        = resp_err_q;

    // Read wins when both enables are high; the write stays asserted by the
    // requester and is picked up on the next IDLE cycle.
    assign accept = O_mem_ready && (I_mem_rd_en || I_mem_wr_en);
    assign acc_wr = accept && !I_mem_rd_en;

    // Range check. Any set bit above the index field means the offset runs
    // past the array (this also catches addresses below BASE_ADDR, but the
    // explicit compare keeps the intent obvious).
    assign off      = I_addr - BASE_ADDR;
    assign in_range = (I_addr >= BASE_ADDR) && ((off >> (AW + 3)) == 64'd0);
    assign idx      = off[AW+2:3];
    assign word     = mem[idx];

    // Load path: shift the addressed lane down, mask to size, then extend
    // from the top bit of the masked field.
    assign shifted = word >> {I_addr[2:0], 3'b000};

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < 8; i++) begin
            lane_mask[8*i +: 8] = {8{I_rstrb[i]}};
        end
    end

    always_comb begin
        sbit = shifted[63];
        case (I_rstrb[7:0])
            8'h01:   sbit = shifted[7];
            8'h03:   sbit = shifted[15];
            8'h0F:   sbit = shifted[31];
            default: sbit = shifted[63];
        endcase
    end

    always_comb begin
        load_val = '0;
        if (in_range) begin
            load_val = (shifted & lane_mask) |
                       ((I_rstrb[8] && sbit) ? ~lane_mask : 64'd0);
        end
    end

    // Store commits at the accept edge so that a later read sees it. Memory
    // is never cleared by reset.
    always_ff @(posedge I_sys_clk) begin
        if (!I_rst && acc_wr && in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (I_wstrb[i]) mem[idx][8*i +: 8] <= I_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            is_rd_q    <= 1'b0;
            err_q      <= 1'b0;
            ldata_q    <= 64'd0;
            rvalid_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            resp_err_q <= 1'b0;
            rdata_q    <= 64'd0;
        end else begin
            // Pulses default low; they are raised only on entry to RESP.
            rvalid_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            resp_err_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        is_rd_q <= I_mem_rd_en;
                        err_q   <= !in_range;
                        if (I_mem_rd_en) ldata_q <= load_val;
                        if (LATENCY == 1) begin
                            state_q    <= S_RESP;
                            rvalid_q   <= I_mem_rd_en;
                            bvalid_q   <= !I_mem_rd_en;
                            resp_err_q <= !in_range;
                            if (I_mem_rd_en) rdata_q <= load_val;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= S_RESP;
                        rvalid_q   <= is_rd_q;
                        bvalid_q   <= !is_rd_q;
                        resp_err_q <= err_q;
                        if (is_rd_q) rdata_q <= ldata_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_040750_dmem_responder.sv
module tb_ysyx_040750_dmem_responder;

    localparam int          MW   = 256;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam int          LAT  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_en = 1'b0, wr_en = 1'b0;
    logic [63:0] addr = '0, wdata = '0;
    logic [7:0]  wstrb = '0;
    logic [8:0]  rstrb = '0;
    logic        ready, rvalid, bvalid, rerr;
    logic [63:0] rdata;

    // second instance, LATENCY=3, used only for the back-pressure timing test
    logic        rd1 = 1'b0;
    logic        ready1, rvalid1, bvalid1, rerr1;
    logic [63:0] rdata1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ysyx_040750_dmem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .I_sys_clk(clk), .I_rst(rst), .I_mem_rd_en(rd_en), .I_mem_wr_en(wr_en),
        .I_addr(addr), .I_wdata(wdata), .I_wstrb(wstrb), .I_rstrb(rstrb),
        .O_mem_ready(ready), .O_mem_data_rvalid(rvalid), .O_mem_data_bvalid(bvalid),
        .O_rdata(rdata), .O_resp_err(rerr));

    ysyx_040750_dmem_responder #(.MEM_WORDS(MW), .BASE_ADDR(BASE), .LATENCY(3)) dut3 (
        .I_sys_clk(clk), .I_rst(rst), .I_mem_rd_en(rd1), .I_mem_wr_en(1'b0),
        .I_addr(BASE), .I_wdata(64'd0), .I_wstrb(8'd0), .I_rstrb(9'h0FF),
        .O_mem_ready(ready1), .O_mem_data_rvalid(rvalid1), .O_mem_data_bvalid(bvalid1),
        .O_rdata(rdata1), .O_resp_err(rerr1));

    typedef struct {
        bit          is_rd;
        logic [63:0] data;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every response pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rvalid && bvalid) chk("both_pulses", 64'd1, 64'd0);
        if (rvalid || bvalid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {62'd0, rvalid, bvalid}, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("resp_type", {63'd0, rvalid}, {63'd0, e.is_rd});
                chk("resp_cycle", 64'(cyc), 64'(e.cyc));
                chk("resp_err", {63'd0, rerr}, {63'd0, e.err});
                if (e.is_rd) chk("rdata", rdata, e.data);
            end
        end
    end

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk({name, "_ready_timeout"}, 64'd0, 64'd1);
    endtask

    // Called at a negedge. Holds the enables until accepted, queues the
    // expected response(s), then drops the enables after the accept edge.
    task automatic req(input bit rd, input bit wr, input logic [63:0] a,
                       input logic [63:0] wd, input logic [7:0] ws, input logic [8:0] rs,
                       input logic [63:0] exp_rd, input bit exp_err);
        exp_t e;
        rd_en = rd; wr_en = wr; addr = a; wdata = wd; wstrb = ws; rstrb = rs;
        wait_ready("req");
        e.is_rd = rd; e.data = exp_rd; e.err = exp_err; e.cyc = cyc + LAT;
        exp_q.push_back(e);
        @(posedge clk); #1;
        rd_en = 1'b0;
        if (rd && wr) begin
            @(negedge clk);
            wait_ready("req_wr");
            e.is_rd = 1'b0; e.data = '0; e.cyc = cyc + LAT;
            exp_q.push_back(e);
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int c1, c2, lowcnt, pcyc, n;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready",  {63'd0, ready},  64'd1);
        chk("rst_rvalid", {63'd0, rvalid}, 64'd0);
        chk("rst_bvalid", {63'd0, bvalid}, 64'd0);
        chk("rst_err",    {63'd0, rerr},   64'd0);
        chk("rst_rdata",  rdata,           64'd0);

        // doubleword round trip
        req(0, 1, BASE + 8, 64'h1122334455667788, 8'hFF, 9'h0, '0, 0);
        req(1, 0, BASE + 8, '0, 8'h0, 9'h0FF, 64'h1122334455667788, 0);

        // byte / halfword extension
        req(0, 1, BASE, 64'h0000_0000_0000_80FF, 8'hFF, 9'h0, '0, 0);
        req(1, 0, BASE + 1, '0, 8'h0, 9'h101, 64'hFFFF_FFFF_FFFF_FF80, 0);
        req(1, 0, BASE + 1, '0, 8'h0, 9'h001, 64'h0000_0000_0000_0080, 0);
        req(1, 0, BASE, '0, 8'h0, 9'h103, 64'hFFFF_FFFF_FFFF_80FF, 0);
        req(1, 0, BASE, '0, 8'h0, 9'h00F, 64'h0000_0000_0000_80FF, 0);

        // partial write merge: only byte 6 of wdata lands
        req(0, 1, BASE + 16, 64'h0, 8'hFF, 9'h0, '0, 0);
        req(0, 1, BASE + 16, 64'h11AB_2233_4455_6677, 8'h40, 9'h0, '0, 0);
        req(1, 0, BASE + 16, '0, 8'h0, 9'h0FF, 64'h00AB_0000_0000_0000, 0);

        // out of range: read below base, write one past the end (its low
        // index bits alias word 0, which must stay untouched)
        req(1, 0, 64'h7FFF_FFF8, '0, 8'h0, 9'h0FF, 64'd0, 1);
        req(0, 1, BASE + 64'(8 * MW), 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, 9'h0, '0, 1);
        req(1, 0, BASE, '0, 8'h0, 9'h0FF, 64'h0000_0000_0000_80FF, 0);

        // zero-strobe write is a no-op with a normal response
        req(0, 1, BASE + 8, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 9'h0, '0, 0);
        req(1, 0, BASE + 8, '0, 8'h0, 9'h0FF, 64'h1122334455667788, 0);

        // both enables: read served with old data, then the write
        req(0, 1, BASE + 24, 64'h5555_5555_5555_5555, 8'hFF, 9'h0, '0, 0);
        req(1, 1, BASE + 24, 64'h0123_4567_89AB_CDEF, 8'hFF, 9'h0FF, 64'h5555_5555_5555_5555, 0);
        req(1, 0, BASE + 24, '0, 8'h0, 9'h0FF, 64'h0123_4567_89AB_CDEF, 0);

        // back-pressure on the LATENCY=3 instance with rd held continuously
        c1 = -1; c2 = -1; lowcnt = 0; pcyc = -1;
        rd1 = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (rvalid1 && pcyc < 0) pcyc = cyc;
            if (ready1 && rd1) begin
                if (c1 < 0) c1 = cyc;
                else if (c2 < 0) c2 = cyc;
            end else if (!ready1 && c1 >= 0 && c2 < 0) begin
                lowcnt++;
            end
            @(negedge clk);
            if (c2 >= 0) rd1 = 1'b0;
        end
        rd1 = 1'b0;
        chk("bp_accept_gap", 64'(c2 - c1), 64'd4);
        chk("bp_ready_low",  64'(lowcnt),  64'd3);
        chk("bp_pulse_cyc",  64'(pcyc),    64'(c1 + 3));

        // reset mid-operation: accepted read loses its response
        wait_ready("rst_mid");
        rd_en = 1'b1; addr = BASE + 8; rstrb = 9'h0FF;
        @(posedge clk); #1;
        rd_en = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_ready", {63'd0, ready}, 64'd1);
        repeat (4) @(negedge clk);
        req(1, 0, BASE + 8, '0, 8'h0, 9'h0FF, 64'h1122334455667788, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
